// File: rtl/apb_upsizer.sv
// apb_upsizer: bridges a 16-bit APB initiator onto a 32-bit APB4 completer.
// Half-word writes are paired through a one-entry buffer; word reads cache the upper half.
module apb_upsizer #(
    parameter int ADDR_W = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSELs,
    input  logic              PENABLEs,
    input  logic              PWRITEs,
    input  logic [ADDR_W-1:0] PADDRs,
    input  logic [15:0]       PWDATAs,
    output logic [15:0]       PRDATAs,
    output logic              PREADYs,
    output logic              PSELm,
    output logic              PENABLEm,
    output logic              PWRITEm,
    output logic [ADDR_W-1:0] PADDRm,
    output logic [31:0]       PWDATAm,
    output logic [3:0]        PSTRBm,
    input  logic [31:0]       PRDATAm,
    input  logic              PREADYm
);
    localparam int WW = ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE, FL_SETUP, FL_ACCESS, XF_SETUP, XF_ACCESS
    } state_t;

    typedef struct packed {
        logic          wr;
        logic          hi;
        logic [WW-1:0] word;
        logic [31:0]   data;
        logic [3:0]    strb;
    } mreq_t;

    state_t        state_q, state_d;
    logic          wbuf_vld_q, wbuf_vld_d;
    logic [WW-1:0] wbuf_word_q, wbuf_word_d;
    logic [15:0]   wbuf_data_q, wbuf_data_d;
    logic          rbuf_vld_q, rbuf_vld_d;
    logic [WW-1:0] rbuf_word_q, rbuf_word_d;
    logic [15:0]   rbuf_data_q, rbuf_data_d;
    logic          psel_q, psel_d;
    logic          penable_q, penable_d;
    mreq_t         m_q, m_d;

    logic          req, hi, same_w, rd_hit, preadys;
    logic [WW-1:0] word;
    logic [15:0]   prdata;
    logic          unused_addr0;

    assign unused_addr0 = PADDRs[0];
    assign req    = PSELs & PENABLEs;
    assign word   = PADDRs[ADDR_W-1:2];
    assign hi     = PADDRs[1];
    assign same_w = wbuf_vld_q && (wbuf_word_q == word);
    assign rd_hit = hi && rbuf_vld_q && (rbuf_word_q == word);

    function automatic mreq_t mk(logic wr, logic h, logic [WW-1:0] w,
                                 logic [31:0] d, logic [3:0] s);
        mreq_t r;
        r.wr   = wr;
        r.hi   = h;
        r.word = w;
        r.data = d;
        r.strb = s;
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        wbuf_vld_d  = wbuf_vld_q;
        wbuf_word_d = wbuf_word_q;
        wbuf_data_d = wbuf_data_q;
        rbuf_vld_d  = rbuf_vld_q;
        rbuf_word_d = rbuf_word_q;
        rbuf_data_d = rbuf_data_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        m_d         = m_q;
        preadys     = 1'b0;
        prdata      = 16'h0;
        case (state_q)
            IDLE: begin
                if (req && PWRITEs) begin
                    rbuf_vld_d = 1'b0;
                    if (!hi && !wbuf_vld_q) begin
                        wbuf_vld_d  = 1'b1;
                        wbuf_word_d = word;
                        wbuf_data_d = PWDATAs;
                        preadys     = 1'b1;
                    end else if (hi && same_w) begin
                        m_d = mk(1'b1, 1'b1, word,
                                 {PWDATAs, wbuf_data_q}, 4'b1111);
                        wbuf_vld_d = 1'b0;
                        state_d    = XF_SETUP;
                        psel_d     = 1'b1;
                    end else if (wbuf_vld_q) begin
                        m_d = mk(1'b1, 1'b0, wbuf_word_q,
                                 {16'h0, wbuf_data_q}, 4'b0011);
                        state_d = FL_SETUP;
                        psel_d  = 1'b1;
                    end else begin
                        m_d = mk(1'b1, 1'b1, word,
                                 {PWDATAs, 16'h0}, 4'b1100);
                        state_d = XF_SETUP;
                        psel_d  = 1'b1;
                    end
                end else if (req) begin
                    if (wbuf_vld_q) begin
                        m_d = mk(1'b1, 1'b0, wbuf_word_q,
                                 {16'h0, wbuf_data_q}, 4'b0011);
                        state_d = FL_SETUP;
                        psel_d  = 1'b1;
                    end else if (rd_hit) begin
                        prdata     = rbuf_data_q;
                        preadys    = 1'b1;
                        rbuf_vld_d = 1'b0;
                    end else begin
                        m_d     = mk(1'b0, hi, word, 32'h0, 4'b0000);
                        state_d = XF_SETUP;
                        psel_d  = 1'b1;
                    end
                end
            end
            FL_SETUP: begin
                state_d   = FL_ACCESS;
                penable_d = 1'b1;
            end
            FL_ACCESS: begin
                if (PREADYm) begin
                    wbuf_vld_d = 1'b0;
                    penable_d  = 1'b0;
                    // Lower writes and read hits re-decode from IDLE.
                    if (req && PWRITEs && hi) begin
                        m_d = mk(1'b1, 1'b1, word,
                                 {PWDATAs, 16'h0}, 4'b1100);
                        state_d = XF_SETUP;
                    end else if (req && !PWRITEs && !rd_hit) begin
                        m_d     = mk(1'b0, hi, word, 32'h0, 4'b0000);
                        state_d = XF_SETUP;
                    end else begin
                        m_d     = '0;
                        psel_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            XF_SETUP: begin
                state_d   = XF_ACCESS;
                penable_d = 1'b1;
            end
            XF_ACCESS: begin
                if (PREADYm) begin
                    preadys = req;
                    if (!m_q.wr) begin
                        prdata = m_q.hi ? PRDATAm[31:16] : PRDATAm[15:0];
                        rbuf_vld_d = !m_q.hi;
                        if (!m_q.hi) begin
                            rbuf_word_d = m_q.word;
                            rbuf_data_d = PRDATAm[31:16];
                        end
                    end
                    m_d       = '0;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            wbuf_vld_q  <= 1'b0;
            wbuf_word_q <= '0;
            wbuf_data_q <= 16'h0;
            rbuf_vld_q  <= 1'b0;
            rbuf_word_q <= '0;
            rbuf_data_q <= 16'h0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            m_q         <= '0;
        end else begin
            state_q     <= state_d;
            wbuf_vld_q  <= wbuf_vld_d;
            wbuf_word_q <= wbuf_word_d;
            wbuf_data_q <= wbuf_data_d;
            rbuf_vld_q  <= rbuf_vld_d;
            rbuf_word_q <= rbuf_word_d;
            rbuf_data_q <= rbuf_data_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            m_q         <= m_d;
        end
    end

    assign PREADYs  = preadys & ~PRESET;
    assign PRDATAs  = PREADYs ? prdata : 16'h0;
    assign PSELm    = psel_q;
    assign PENABLEm = penable_q;
    assign PWRITEm  = m_q.wr;
    assign PADDRm   = {m_q.word, 2'b00};
    assign PWDATAm  = m_q.data;
    assign PSTRBm   = m_q.strb;

endmodule
